// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between
// instruction fetch (ch0) and data load/store (ch1).
module memory_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,

   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_address,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req0_write,
   output logic                  req0_ready,
   output logic                  req0_rvalid,
   output logic [DATA_WIDTH-1:0] req0_rdata,

   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_address,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic                  req1_write,
   output logic                  req1_ready,
   output logic                  req1_rvalid,
   output logic [DATA_WIDTH-1:0] req1_rdata,

   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_write,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,

   output logic                  grant_sel
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t state, state_nxt;
   logic   grant_nxt;
   logic   last_grant, last_nxt;

   // last_grant resets to ch1 so the first tie after reset goes to ch0
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         grant_sel  <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant_sel  <= grant_nxt;
         last_grant <= last_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_sel;
      last_nxt    = last_grant;
      mem_valid   = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      req0_rvalid = 1'b0;
      req1_rvalid = 1'b0;
      case (state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant_nxt = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               req0_ready = ~grant_sel;
               req1_ready = grant_sel;
               state_nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               req0_rvalid = ~grant_sel;
               req1_rvalid = grant_sel;
               last_nxt    = grant_sel;
               state_nxt   = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign mem_address = grant_sel ? req1_address : req0_address;
   assign mem_wdata   = grant_sel ? req1_wdata   : req0_wdata;
   assign mem_write   = grant_sel ? req1_write   : req0_write;
   assign req0_rdata  = mem_rdata;
   assign req1_rdata  = mem_rdata;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: directed scenarios plus a
// traffic engine that records each completed transaction for comparison.
module tb_memory_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_write, req0_ready, req0_rvalid;
   logic [31:0] req0_address, req0_wdata, req0_rdata;
   logic        req1_valid, req1_write, req1_ready, req1_rvalid;
   logic [31:0] req1_address, req1_wdata, req1_rdata;
   logic        mem_valid, mem_ready, mem_write, mem_rvalid, grant_sel;
   logic [31:0] mem_address, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ch;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        gch;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        wr;
      logic        rdy;
      logic        rdyok;
      logic        rch;
      logic        rboth;
      logic [31:0] rdata;
      int          acc;
      int          rsp;
   } obs_t;

   exp_t sb[$];
   obs_t obs[$];

   memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_address(req0_address), .req0_wdata(req0_wdata),
      .req0_write(req0_write), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
      .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_address(req1_address), .req1_wdata(req1_wdata),
      .req1_write(req1_write), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
      .req1_rdata(req1_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .grant_sel(grant_sel)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'h3C3C_0000;
   endfunction

   // inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      req0_valid = 0; req0_address = '0; req0_wdata = '0; req0_write = 0;
      req1_valid = 0; req1_address = '0; req1_wdata = '0; req1_write = 0;
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      clear_inputs();
      step(); step();
      reset = 0;
   endtask

   task automatic run_traffic(input int n0, input int n1, input logic [31:0] base0,
                              input logic [31:0] base1, input int rdelay,
                              input int budget, output bit to);
      int   sent0 = 0;
      int   sent1 = 0;
      int   done  = 0;
      int   cyc   = 0;
      int   resp  = -1;
      obs_t cur;
      cur = '{default: '0};
      obs.delete();
      while (done < n0 + n1 && cyc < budget) begin
         step();
         req0_valid   = (sent0 < n0);
         req0_address = base0 + 32'(4 * sent0);
         req0_write   = sent0[0];
         req0_wdata   = ~req0_address;
         req1_valid   = (sent1 < n1);
         req1_address = base1 + 32'(4 * sent1);
         req1_write   = sent1[0];
         req1_wdata   = ~req1_address;
         mem_ready    = 1;
         mem_rvalid   = (cyc == resp);
         mem_rdata    = mem_rvalid ? rd_of(cur.addr) : 32'h0;
         settle();
         if (mem_valid && mem_ready) begin
            cur.gch   = grant_sel;
            cur.addr  = mem_address;
            cur.wr    = mem_write;
            cur.wd    = mem_wdata;
            cur.rdy   = req1_ready;
            cur.rdyok = req0_ready ^ req1_ready;
            cur.acc   = cyc;
            resp      = cyc + rdelay;
         end
         if (req0_ready) sent0++;
         if (req1_ready) sent1++;
         if (req0_rvalid || req1_rvalid) begin
            cur.rch   = req1_rvalid;
            cur.rboth = req0_rvalid && req1_rvalid;
            cur.rdata = req1_rvalid ? req1_rdata : req0_rdata;
            cur.rsp   = cyc;
            obs.push_back(cur);
            done++;
         end
         cyc++;
      end
      to = (done < n0 + n1);
      step();
      clear_inputs();
      settle();
   endtask

   task automatic test_reset();
      reset = 1;
      clear_inputs();
      req0_valid = 1; req1_valid = 1; mem_ready = 1; mem_rvalid = 1;
      step(); step();
      settle();
      checks++;
      if ({mem_valid, grant_sel, req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 000000",
                  {mem_valid, grant_sel, req0_ready, req1_ready, req0_rvalid, req1_rvalid});
      end
      clear_inputs();
      reset = 0;
   endtask

   task automatic test_single_load();
      exp_t e;
      step();
      req0_valid = 1; req0_address = 32'h100; req0_write = 0; mem_ready = 1;
      sb.push_back('{ch: 0, addr: 32'h100, wdata: 32'h0, wr: 0, rdata: 32'hDEADBEEF});
      settle();
      checks++;
      if (mem_valid !== 1'b0) begin errors++; $display("FAIL t1_idle_mem_valid got %b want 0", mem_valid); end
      step(); settle();
      checks++;
      if ({mem_valid, req0_ready, req1_ready, grant_sel} !== 4'b1100) begin
         errors++; $display("FAIL t1_issue {valid,rdy0,rdy1,grant} got %b want 1100",
                            {mem_valid, req0_ready, req1_ready, grant_sel});
      end
      checks++;
      if (mem_address !== sb[0].addr) begin
         errors++; $display("FAIL t1_address got %h want %h", mem_address, sb[0].addr);
      end
      step();
      req0_valid = 0;
      settle();
      checks++;
      if ({mem_valid, req0_ready, req0_rvalid, req1_rvalid} !== 4'b0) begin
         errors++; $display("FAIL t1_wait got %b want 0000", {mem_valid, req0_ready, req0_rvalid, req1_rvalid});
      end
      step();
      mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      settle();
      e = sb.pop_front();
      checks++;
      if ({req0_rvalid, req1_rvalid, req1_ready} !== 3'b100 || req0_rdata !== e.rdata) begin
         errors++; $display("FAIL t1_response rvalid0/1,rdy1=%b rdata=%h want 100 %h",
                            {req0_rvalid, req1_rvalid, req1_ready}, req0_rdata, e.rdata);
      end
      step();
      mem_rvalid = 0;
      settle();
      checks++;
      if ({req0_rvalid, req1_rvalid, mem_valid} !== 3'b0) begin
         errors++; $display("FAIL t1_rvalid_pulse got %b want 000", {req0_rvalid, req1_rvalid, mem_valid});
      end
   endtask

   task automatic test_tie_after_reset();
      bit   to;
      exp_t e;
      obs_t o;
      int   prev_rsp = 0;
      do_reset();
      sb.push_back('{ch: 0, addr: 32'h1000, wdata: ~32'h1000, wr: 0, rdata: rd_of(32'h1000)});
      sb.push_back('{ch: 1, addr: 32'h2000, wdata: ~32'h2000, wr: 0, rdata: rd_of(32'h2000)});
      run_traffic(1, 1, 32'h1000, 32'h2000, 1, 30, to);
      checks++;
      if (to !== 1'b0 || obs.size() != 2) begin
         errors++; $display("FAIL tie_timeout timeout=%0d txns=%0d want 0 2", to, obs.size());
         sb.delete();
      end
      for (int i = 0; i < 2 && obs.size() > 0; i++) begin
         e = sb.pop_front();
         o = obs.pop_front();
         checks++;
         if (o.gch !== e.ch || o.rch !== e.ch || o.addr !== e.addr || o.rdata !== e.rdata) begin
            errors++; $display("FAIL tie_txn%0d grant=%b rch=%b addr=%h rdata=%h want %b %b %h %h",
                               i, o.gch, o.rch, o.addr, o.rdata, e.ch, e.ch, e.addr, e.rdata);
         end
         if (i == 1) begin
            checks++;
            if (o.acc != prev_rsp + 2) begin
               errors++; $display("FAIL tie_gap accept=%0d want %0d", o.acc, prev_rsp + 2);
            end
         end
         prev_rsp = o.rsp;
      end
   endtask

   task automatic test_contention();
      bit          to;
      exp_t        e;
      obs_t        o;
      logic [31:0] a;
      int          prev_rsp = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a = (i % 2 == 0) ? 32'h1000 + 32'(4 * (i / 2)) : 32'h2000 + 32'(4 * (i / 2));
         sb.push_back('{ch: 1'(i % 2), addr: a, wdata: ~a, wr: 1'((i / 2) % 2), rdata: rd_of(a)});
      end
      run_traffic(3, 3, 32'h1000, 32'h2000, 2, 80, to);
      checks++;
      if (to !== 1'b0 || obs.size() != 6) begin
         errors++; $display("FAIL rr_timeout timeout=%0d txns=%0d want 0 6", to, obs.size());
      end
      for (int i = 0; i < 6 && obs.size() > 0; i++) begin
         e = sb.pop_front();
         o = obs.pop_front();
         checks++;
         if (o.gch !== e.ch || o.rdy !== e.ch || o.rdyok !== 1'b1) begin
            errors++; $display("FAIL rr_grant%0d grant=%b ready_ch=%b one_hot=%b want %b %b 1",
                               i, o.gch, o.rdy, o.rdyok, e.ch, e.ch);
         end
         checks++;
         if (o.addr !== e.addr || o.wd !== e.wdata || o.wr !== e.wr) begin
            errors++; $display("FAIL rr_mux%0d addr=%h wdata=%h write=%b want %h %h %b",
                               i, o.addr, o.wd, o.wr, e.addr, e.wdata, e.wr);
         end
         checks++;
         if (o.rch !== e.ch || o.rboth !== 1'b0 || o.rdata !== e.rdata) begin
            errors++; $display("FAIL rr_resp%0d rch=%b both=%b rdata=%h want %b 0 %h",
                               i, o.rch, o.rboth, o.rdata, e.ch, e.rdata);
         end
         if (i > 0) begin
            checks++;
            if (o.acc != prev_rsp + 2) begin
               errors++; $display("FAIL rr_gap%0d accept=%0d want %0d", i, o.acc, prev_rsp + 2);
            end
         end
         prev_rsp = o.rsp;
      end
      sb.delete();
   endtask

   task automatic test_stall();
      exp_t e;
      bit   got = 0;
      bit   drop = 0;
      int   rc = -1;
      do_reset();
      sb.push_back('{ch: 0, addr: 32'h300, wdata: 32'h1234, wr: 1, rdata: 32'h0BADF00D});
      step();
      req0_valid = 1; req0_address = 32'h300; req0_write = 1; req0_wdata = 32'h1234; mem_ready = 0;
      settle();
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 0) begin req1_valid = 1; req1_address = 32'h400; req1_write = 0; req1_wdata = 32'h55; end
         mem_rvalid = (i == 2);
         settle();
         checks++;
         if ({mem_valid, grant_sel, mem_write, req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 7'b1010000
             || mem_address !== 32'h300) begin
            errors++; $display("FAIL stall%0d ctl=%b addr=%h want 1010000 00000300", i,
               {mem_valid, grant_sel, mem_write, req0_ready, req1_ready, req0_rvalid, req1_rvalid}, mem_address);
         end
      end
      step();
      mem_ready = 1; mem_rvalid = 1;
      settle();
      checks++;
      if ({req0_ready, req1_ready, req0_rvalid} !== 3'b100 || mem_wdata !== sb[0].wdata) begin
         errors++; $display("FAIL stall_accept rdy0,rdy1,rv0=%b wdata=%h want 100 %h",
                            {req0_ready, req1_ready, req0_rvalid}, mem_wdata, sb[0].wdata);
      end
      step();
      req0_valid = 0; mem_rvalid = 0;
      settle();
      checks++;
      if ({mem_valid, req0_rvalid, req1_rvalid} !== 3'b0) begin
         errors++; $display("FAIL same_cycle_rvalid got %b want 000", {mem_valid, req0_rvalid, req1_rvalid});
      end
      step();
      mem_rvalid = 1; mem_rdata = 32'h0BADF00D;
      settle();
      e = sb.pop_front();
      checks++;
      if ({req0_rvalid, req1_rvalid} !== 2'b10 || req0_rdata !== e.rdata) begin
         errors++; $display("FAIL stall_resp rv=%b rdata=%h want 10 %h", {req0_rvalid, req1_rvalid}, req0_rdata, e.rdata);
      end
      sb.push_back('{ch: 1, addr: 32'h400, wdata: 32'h55, wr: 0, rdata: rd_of(32'h400)});
      for (int cyc = 0; cyc < 12 && !got; cyc++) begin
         step();
         if (drop) req1_valid = 0;
         mem_rvalid = (cyc == rc);
         mem_rdata  = rd_of(32'h400);
         settle();
         if (req1_ready) begin
            checks++;
            if (grant_sel !== 1'b1 || mem_address !== sb[0].addr) begin
               errors++; $display("FAIL drain_issue grant=%b addr=%h want 1 %h", grant_sel, mem_address, sb[0].addr);
            end
            drop = 1;
            rc = cyc + 2;
         end
         if (req0_rvalid) begin
            checks++; errors++;
            $display("FAIL drain_ch0_rvalid got 1 want 0");
         end
         if (req1_rvalid) begin
            e = sb.pop_front();
            got = 1;
            checks++;
            if (req1_rdata !== e.rdata) begin
               errors++; $display("FAIL drain_rdata got %h want %h", req1_rdata, e.rdata);
            end
         end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL drain_timeout got 0 want 1"); sb.delete(); end
      step();
      clear_inputs();
   endtask

   task automatic test_reset_in_wait();
      bit to;
      do_reset();
      run_traffic(1, 0, 32'h5000, 32'h0, 1, 20, to);
      checks++;
      if (to !== 1'b0 || obs.size() != 1 || obs[0].gch !== 1'b0) begin
         errors++; $display("FAIL rst_prep timeout=%0d txns=%0d want 0 1", to, obs.size());
      end
      step();
      req1_valid = 1; req1_address = 32'h600;
      settle();
      step();
      mem_ready = 1;
      settle();
      checks++;
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL rst_accept got %b want 1", req1_ready); end
      step();
      req1_valid = 0; mem_ready = 0; reset = 1;
      settle();
      checks++;
      if ({mem_valid, grant_sel} !== 2'b01) begin
         errors++; $display("FAIL rst_in_wait valid,grant got %b want 01", {mem_valid, grant_sel});
      end
      step();
      reset = 0; mem_rvalid = 1; mem_rdata = 32'h66;
      settle();
      checks++;
      if ({mem_valid, grant_sel, req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 6'b0) begin
         errors++; $display("FAIL rst_dropped got %b want 000000",
            {mem_valid, grant_sel, req0_ready, req1_ready, req0_rvalid, req1_rvalid});
      end
      step();
      mem_rvalid = 0;
      settle();
      checks++;
      if ({mem_valid, req0_rvalid, req1_rvalid} !== 3'b0) begin
         errors++; $display("FAIL rst_idle got %b want 000", {mem_valid, req0_rvalid, req1_rvalid});
      end
      run_traffic(1, 1, 32'h7000, 32'h8000, 1, 30, to);
      checks++;
      if (to !== 1'b0 || obs.size() != 2) begin
         errors++; $display("FAIL rst_tie_timeout timeout=%0d txns=%0d want 0 2", to, obs.size());
      end else begin
         checks++;
         if (obs[0].gch !== 1'b0 || obs[1].gch !== 1'b1) begin
            errors++; $display("FAIL rst_tie_order got %b%b want 01", obs[0].gch, obs[1].gch);
         end
      end
   endtask

   task automatic test_stray_rvalid();
      bit to;
      step();
      mem_rvalid = 1; mem_rdata = 32'hFFFF;
      settle();
      checks++;
      if ({mem_valid, req0_rvalid, req1_rvalid} !== 3'b0) begin
         errors++; $display("FAIL stray_rvalid got %b want 000", {mem_valid, req0_rvalid, req1_rvalid});
      end
      step();
      mem_rvalid = 0;
      settle();
      run_traffic(1, 0, 32'h9000, 32'h0, 1, 20, to);
      checks++;
      if (to !== 1'b0 || obs.size() != 1) begin
         errors++; $display("FAIL stray_timeout timeout=%0d txns=%0d want 0 1", to, obs.size());
      end else begin
         checks++;
         if (obs[0].acc != 1 || obs[0].rch !== 1'b0 || obs[0].rdata !== rd_of(32'h9000)) begin
            errors++; $display("FAIL stray_followup accept=%0d rch=%b rdata=%h want 1 0 %h",
                               obs[0].acc, obs[0].rch, obs[0].rdata, rd_of(32'h9000));
         end
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      test_reset();
      test_single_load();
      test_tie_after_reset();
      test_contention();
      test_stall();
      test_reset_in_wait();
      test_stray_rvalid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
